// File: rtl/bb_decimator_if.sv
// Baseband I/Q stream into the decimator plus the decimated I/Q result.
// master drives samples and controls; slave is the decimator.
interface bb_decimator_if #(
  parameter int W = 12
);
  logic                in_valid;
  logic signed [W-1:0] i_in;
  logic signed [W-1:0] q_in;
  logic [2:0]          dec_log2;
  logic                bypass;
  logic signed [W-1:0] i_out;
  logic signed [W-1:0] q_out;
  logic                out_valid;

  modport master (
    output in_valid, i_in, q_in, dec_log2, bypass,
    input  i_out, q_out, out_valid
  );

  modport slave (
    input  in_valid, i_in, q_in, dec_log2, bypass,
    output i_out, q_out, out_valid
  );
endinterface

// File: rtl/bb_decimator.sv
// Integrate-and-dump I/Q decimator: averages 2^dec blocks with round-half-up; result registered
// on the edge taking the block's last sample. No backpressure: one sample per clock, always accepted.
module bb_decimator #(
  parameter int W        = 12,
  parameter int MAX_LOG2 = 4
) (
  input  logic            clk,
  input  logic            rst,
  bb_decimator_if.slave   dec_if
);
  localparam int AW = W + MAX_LOG2;

  logic [MAX_LOG2-1:0] cnt_q, cnt_d;
  logic signed [AW-1:0] iacc_q, iacc_d, qacc_q, qacc_d;
  logic [2:0]          dec_act_q, dec_act_d;
  logic signed [W-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
  logic                out_valid_q, out_valid_d;

  logic [2:0]          eff;
  logic [MAX_LOG2-1:0] last_cnt;
  logic signed [AW-1:0] ext_i, ext_q, sum_i, sum_q, rnd, rsum_i, rsum_q;

  always_comb begin
    cnt_d       = cnt_q;
    iacc_d      = iacc_q;
    qacc_d      = qacc_q;
    dec_act_d   = dec_act_q;
    i_out_d     = i_out_q;
    q_out_d     = q_out_q;
    out_valid_d = 1'b0;

    // The exponent is only sampled at block start; mid-block changes wait.
    if (cnt_q == '0)
      eff = (dec_if.dec_log2 > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : dec_if.dec_log2;
    else
      eff = dec_act_q;

    last_cnt = MAX_LOG2'((32'd1 << eff) - 32'd1);
    ext_i    = {{MAX_LOG2{dec_if.i_in[W-1]}}, dec_if.i_in};
    ext_q    = {{MAX_LOG2{dec_if.q_in[W-1]}}, dec_if.q_in};
    sum_i    = ((cnt_q == '0) ? '0 : iacc_q) + ext_i;
    sum_q    = ((cnt_q == '0) ? '0 : qacc_q) + ext_q;

    rnd = '0;
    if (eff != 3'd0)
      rnd = AW'(32'd1 << (eff - 3'd1));
    rsum_i = sum_i + rnd;
    rsum_q = sum_q + rnd;

    if (dec_if.bypass) begin
      cnt_d       = '0;
      iacc_d      = '0;
      qacc_d      = '0;
      out_valid_d = dec_if.in_valid;
      if (dec_if.in_valid) begin
        i_out_d = dec_if.i_in;
        q_out_d = dec_if.q_in;
      end
    end else if (dec_if.in_valid) begin
      dec_act_d = eff;
      iacc_d    = sum_i;
      qacc_d    = sum_q;
      if (cnt_q == last_cnt) begin
        // Worst-case sum fits AW bits, so the average always fits W bits.
        i_out_d     = W'(rsum_i >>> eff);
        q_out_d     = W'(rsum_q >>> eff);
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + MAX_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      iacc_q      <= '0;
      qacc_q      <= '0;
      dec_act_q   <= '0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      iacc_q      <= iacc_d;
      qacc_q      <= qacc_d;
      dec_act_q   <= dec_act_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dec_if.i_out     = i_out_q;
  assign dec_if.q_out     = q_out_q;
  assign dec_if.out_valid = out_valid_q;
endmodule

// File: tb/tb_bb_decimator.sv
// Bench for bb_decimator: directed scenarios then random traffic, checked every cycle
// against a block-averaging model built on sample queues.
module tb_bb_decimator;
  localparam int W = 12;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bb_decimator_if #(.W(W)) dif ();

  bb_decimator #(.W(W), .MAX_LOG2(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .dec_if (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int q_i[$];
  int q_q[$];
  int n_cur;
  int exp_i;
  int exp_q;
  int exp_v;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int floor_div(input int x, input int n);
    if (x >= 0) return x / n;
    return -((-x + n - 1) / n);
  endfunction

  function automatic int block_avg(input int s[$]);
    int sum;
    int n;
    sum = 0;
    n = s.size();
    foreach (s[k]) sum += s[k];
    if (n > 1) sum += n / 2;
    return floor_div(sum, n);
  endfunction

  task automatic model(input bit r, input bit v, input int iv, input int qv,
                       input int d, input bit b);
    if (r) begin
      q_i.delete(); q_q.delete();
      exp_i = 0; exp_q = 0; exp_v = 0;
    end else if (b) begin
      q_i.delete(); q_q.delete();
      exp_v = v;
      if (v) begin exp_i = iv; exp_q = qv; end
    end else begin
      exp_v = 0;
      if (v) begin
        if (q_i.size() == 0) n_cur = 1 << ((d > 4) ? 4 : d);
        q_i.push_back(iv);
        q_q.push_back(qv);
        if (q_i.size() == n_cur) begin
          exp_i = block_avg(q_i);
          exp_q = block_avg(q_q);
          exp_v = 1;
          q_i.delete(); q_q.delete();
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input int iv, input int qv,
                      input int d, input bit b);
    rst          = r;
    dif.in_valid = v;
    dif.i_in     = W'(iv);
    dif.q_in     = W'(qv);
    dif.dec_log2 = 3'(d);
    dif.bypass   = b;
    @(posedge clk);
    #1;
    model(r, v, iv, qv, d, b);
    chk("out_valid", int'(dif.out_valid), exp_v);
    chk("i_out", int'(dif.i_out), exp_i);
    chk("q_out", int'(dif.q_out), exp_q);
  endtask

  initial begin
    int iv, qv, d;
    bit v, b, r;
    total = 0; bad = 0;
    n_cur = 1; exp_i = 0; exp_q = 0; exp_v = 0;

    // Reset dominates a valid sample
    step(1, 1, 500, 500, 2, 0);
    step(1, 1, 500, 500, 2, 0);
    // Constant average, N=4, strobe every 4th sample
    for (int k = 0; k < 8; k++) step(0, 1, 100, -100, 2, 0);
    // Rounding, N=2
    step(0, 1, 1, -1, 1, 0);
    step(0, 1, 2, -2, 1, 0);
    chk("round_i", int'(dif.i_out), 2);
    chk("round_q", int'(dif.q_out), -1);
    // Extremes, N=16
    for (int k = 0; k < 16; k++) step(0, 1, -2048, 2047, 4, 0);
    chk("min_i", int'(dif.i_out), -2048);
    for (int k = 0; k < 16; k++) step(0, 1, 2047, -2048, 4, 0);
    chk("max_i", int'(dif.i_out), 2047);
    // Gapped input, average 25
    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 10 * k, -10 * k, 2, 0);
      step(0, 0, 0, 0, 2, 0);
    end
    chk("gap_i", int'(dif.i_out), 25);
    // Ratio change mid-block: block finishes with N=4, then pass-through
    step(0, 1, 1, 1, 2, 0);
    step(0, 1, 2, 2, 2, 0);
    step(0, 1, 3, 3, 0, 0);
    step(0, 1, 4, 4, 0, 0);
    chk("ratio_hold_i", int'(dif.i_out), 3);
    for (int k = 0; k < 3; k++) step(0, 1, 7 * k - 5, 9 - k, 0, 0);
    // dec_log2=7 clamps to 16
    for (int k = 0; k < 16; k++) step(0, 1, k * 10, -k, 7, 0);
    // Bypass after partial block, then fresh block
    for (int k = 0; k < 3; k++) step(0, 1, 5, 5, 2, 0);
    step(0, 1, 5, 6, 2, 1);
    step(0, 0, 0, 0, 2, 1);
    step(0, 1, 5, 7, 2, 1);
    for (int k = 0; k < 4; k++) step(0, 1, 8, -8, 2, 0);
    chk("bypass_fresh_i", int'(dif.i_out), 8);
    // Reset mid-block discards the partial block
    step(0, 1, 100, 100, 2, 0);
    step(0, 1, 100, 100, 2, 0);
    step(1, 0, 0, 0, 2, 0);
    for (int k = 0; k < 4; k++) step(0, 1, -7, 3, 2, 0);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(199) == 0);
      b  = ($urandom_range(29) == 0);
      v  = ($urandom_range(3) != 0);
      d  = ($urandom_range(9) == 0) ? int'($urandom_range(7)) : 3;
      iv = int'($urandom_range(4095)) - 2048;
      qv = int'($urandom_range(4095)) - 2048;
      step(r, v, iv, qv, d, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bb_decimator.md
# bb_decimator

Integrate-and-dump decimator that consumes the baseband I/Q stream produced by the IF-to-baseband shifter. It averages blocks of 2^dec_log2 consecutive valid samples per channel, rounds, and emits one decimated I/Q pair with a single-cycle valid strobe. A bypass mode passes samples straight through, registered, for debug and for the shifter's own bypass path.

## Interface
- W, 12, sample width of I/Q in and out (signed two's complement)
- MAX_LOG2, 4, largest supported decimation exponent (N max = 16)

- clk  input  1  rising-edge clock, single domain
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  i_in/q_in carry a new sample this cycle
- i_in  input  W  baseband I sample, signed
- q_in  input  W  baseband Q sample, signed
- dec_log2  input  3  decimation exponent; N = 2^dec_log2; values > MAX_LOG2 clamp to MAX_LOG2
- bypass  input  1  1 = registered pass-through, no averaging
- i_out  output  W  decimated I, signed, held between strobes
- q_out  output  W  decimated Q, signed, held between strobes
- out_valid  output  1  one-cycle strobe: i_out/q_out updated this cycle

## Operation
- State: cnt (MAX_LOG2 bits), acc_i/acc_q (W+MAX_LOG2 bits, signed), dec_act (latched exponent).
- Reset (rst=1 at clk edge): i_out=0, q_out=0, out_valid=0, cnt=0, acc_i=acc_q=0, dec_act=0. Reset has priority over every other input.
- in_valid=0: no state change; out_valid=0; outputs hold.
- Block start (in_valid=1, cnt=0): dec_act <= clamp(dec_log2); acc <= sign-extended sample. dec_log2 changes at any other time are ignored until the next block start.
- Within block (in_valid=1, 0<cnt<N-1): acc <= acc + sample; cnt <= cnt+1.
- Last sample (in_valid=1, cnt=N-1, using dec_act): sum = acc + sample; out = (sum + 2^(dec_act-1)) >>> dec_act (round half up; no rounding add when dec_act=0); i_out/q_out <= out[W-1:0]; out_valid <= 1; cnt <= 0.
- dec_act=0 (N=1): every valid sample is both block start and last sample; output = input, registered.
- Width: sum bounded by ±2^(W-1)·N, so 16-bit accumulator never overflows; rounded result always lies in [-2048, 2047] for W=12; no saturation logic. Verification asserts range.
- bypass=1: i_out <= i_in, q_out <= q_in when in_valid=1; out_valid <= in_valid; cnt and accumulators cleared to 0 every cycle so averaging restarts with a fresh block when bypass drops.
- bypass deasserted mid-stream: the first valid sample afterwards is a block start.

## Timing
- Throughput: one sample per clock per channel; no backpressure, no ready signal.
- Latency: out_valid and new i_out/q_out appear on the clock edge that registers the last sample of a block (visible one cycle after the sample is presented).
- Strobe spacing: exactly N valid input samples between consecutive out_valid pulses, independent of gaps in in_valid.
- rst asserted mid-block: partial block discarded; first valid sample after rst deasserts starts a new block.
- out_valid never asserted for two consecutive cycles unless N=1 or bypass.

## Test plan
- Reset: rst=1 two cycles with in_valid=1, i_in=500 -> i_out=q_out=0, out_valid=0 throughout; after release with dec_log2=2, first strobe only after 4 valid samples.
- Constant average: dec_log2=2, i_in=100, q_in=-100 every cycle -> out_valid every 4th cycle, i_out=100, q_out=-100.
- Rounding: dec_log2=1, I samples 1,2 and Q samples -1,-2 -> i_out=2 ((3+1)>>>1), q_out=-1 ((-3+1)>>>1); extremes I=-2048×16 at dec_log2=4 -> -2048, I=2047×16 -> 2047.
- Gapped input: dec_log2=2, in_valid alternating 1/0, I=10,20,30,40 -> single strobe after 4th valid sample, i_out=25; outputs hold, out_valid=0 on idle cycles.
- Ratio change mid-block: dec_log2 switched 2->0 after 2 of 4 samples -> current block completes with N=4 (strobe after 4th sample), subsequent samples passed per cycle; dec_log2=7 behaves as 4.
- Bypass: bypass=1 after 3 of 4 samples with I=5 -> next cycle i_out=5, out_valid=1 per valid sample; bypass=0 then 4 samples of 8 -> strobe with i_out=8, no contamination from the discarded partial block.
